// File: rtl/systolic_skew_buffer.sv
// Staggers a multi-lane beat stream so lane k emerges BASE_DLY+k enabled cycles after acceptance,
// feeding a systolic array edge; tracks stream end and pulses done once the last beat has drained.
module systolic_skew_buffer #(
    parameter int unsigned DATA_WIDTH = 18,
    parameter int unsigned LANES      = 4,
    parameter int unsigned BASE_DLY   = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        ce,
    input  logic                        in_valid,
    input  logic                        in_last,
    input  logic [LANES*DATA_WIDTH-1:0] in_data,
    output logic                        in_ready,
    output logic [LANES-1:0]            out_valid,
    output logic [LANES*DATA_WIDTH-1:0] out_data,
    output logic                        out_last,
    output logic                        done
);

    localparam int unsigned LAST_DEPTH = BASE_DLY + LANES - 1;
    localparam int unsigned CNT_W      = $clog2(BASE_DLY + LANES) + 1;
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(LAST_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    logic [LANES*DATA_WIDTH-1:0] in_q_data;
    logic                        in_q_valid;
    logic                        in_q_last;

    assign in_ready = ce & ((state_q == ST_IDLE) | (state_q == ST_STREAM));
    assign accept   = in_valid & in_ready;
    assign done     = (state_q == ST_DONE);

    // Shared entry stage: non-accepted edges inject a zero bubble, so every
    // downstream register already holds zero data whenever its valid is low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            in_q_data  <= '0;
            in_q_valid <= 1'b0;
            in_q_last  <= 1'b0;
        end else if (ce) begin
            in_q_data  <= accept ? in_data : '0;
            in_q_valid <= accept;
            in_q_last  <= accept & in_last;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam int unsigned DEPTH = BASE_DLY + k;

        logic [DATA_WIDTH-1:0] dq [DEPTH];
        logic                  vq [DEPTH];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    dq[i] <= '0;
                    vq[i] <= 1'b0;
                end
            end else if (ce) begin
                dq[0] <= in_q_data[k*DATA_WIDTH +: DATA_WIDTH];
                vq[0] <= in_q_valid;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    dq[i] <= dq[i-1];
                    vq[i] <= vq[i-1];
                end
            end
        end

        assign out_data[k*DATA_WIDTH +: DATA_WIDTH] = dq[DEPTH-1];
        assign out_valid[k]                          = vq[DEPTH-1];
    end

    logic lq [LAST_DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < LAST_DEPTH; i++) begin
                lq[i] <= 1'b0;
            end
        end else if (ce) begin
            lq[0] <= in_q_last;
            for (int unsigned i = 1; i < LAST_DEPTH; i++) begin
                lq[i] <= lq[i-1];
            end
        end
    end

    assign out_last = lq[LAST_DEPTH-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else if (ce) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Drain counter is sized so DONE lands on the same edge that the last
    // beat's final lane (and out_last) reaches the outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_STREAM: begin
                if (accept) begin
                    if (in_last) begin
                        state_d = ST_DRAIN;
                        cnt_d   = DRAIN_LOAD;
                    end else begin
                        state_d = ST_STREAM;
                    end
                end
            end
            ST_DRAIN: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
